// File: rtl/fetch_stage_pkg.sv
// Shared pipeline constants: NOP encoding, opcodes, default reset PC.
package fetch_stage_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam logic [31:0] NOP = '0;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD  = 6'h00,
    OP_JUMP = 6'h02,
    OP_BEQ  = 6'h04,
    OP_BNE  = 6'h05,
    OP_ADDI = 6'h08,
    OP_LW   = 6'h23,
    OP_SW   = 6'h2B
  } opcode_e;

  // Pseudo-direct jump: upper nibble of PC+4 with the word-aligned 26-bit index.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [31:0] instr);
    return {pc_plus4[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction memory port, IF/ID outputs.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic                stall;
  logic                branch_taken;
  logic [31:0]         branch_target;
  logic                jump;
  logic [31:0]         imem_address;
  logic [31:0]         imem_data;
  logic [31:0]         if_id_instruction;
  logic [31:0]         if_id_pc_plus4;
  logic                if_id_valid;
  logic [OPCODE_W-1:0] opcode;
  logic                flush_id_ex;

  modport master (
    input  stall, branch_taken, branch_target, jump, imem_data,
    output imem_address, if_id_instruction, if_id_pc_plus4, if_id_valid,
           opcode, flush_id_ex
  );

  modport slave (
    output stall, branch_taken, branch_target, jump, imem_data,
    input  imem_address, if_id_instruction, if_id_pc_plus4, if_id_valid,
           opcode, flush_id_ex
  );

endinterface

// File: rtl/fetch_stage_pc_register.sv
// Program counter: loads load_value when enabled, synchronous reset to RESET_PC.
module pc_register
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] load_value,
  output logic [31:0] pc
);

  logic [31:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (enable) pc_d = load_value;
  end

  always_ff @(posedge clock) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC selection (branch > jump > stall > sequential) and IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic clock,
  input  logic reset,
  fetch_stage_if.master fif
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_load;
  logic        pc_enable;
  logic        jump_eff;

  logic [31:0] if_id_instruction_d, if_id_instruction_q;
  logic [31:0] if_id_pc_plus4_d, if_id_pc_plus4_q;
  logic        if_id_valid_d, if_id_valid_q;

  assign pc_plus4 = pc + 32'd4;
  // A jump decoded from a bubble is not a real jump.
  assign jump_eff = fif.jump & if_id_valid_q;

  always_comb begin
    pc_load   = pc_plus4;
    pc_enable = 1'b1;
    if (fif.branch_taken)   pc_load = fif.branch_target;
    else if (jump_eff)      pc_load = jump_target(if_id_pc_plus4_q, if_id_instruction_q);
    else if (fif.stall)     pc_enable = 1'b0;
  end

  pc_register #(.RESET_PC(RESET_PC)) u_pc (
    .clock      (clock),
    .reset      (reset),
    .enable     (pc_enable),
    .load_value (pc_load),
    .pc         (pc)
  );

  always_comb begin
    if_id_instruction_d = if_id_instruction_q;
    if_id_pc_plus4_d    = if_id_pc_plus4_q;
    if_id_valid_d       = if_id_valid_q;
    if (fif.branch_taken || jump_eff) begin
      if_id_instruction_d = NOP;
      if_id_pc_plus4_d    = '0;
      if_id_valid_d       = 1'b0;
    end else if (!fif.stall) begin
      if_id_instruction_d = fif.imem_data;
      if_id_pc_plus4_d    = pc_plus4;
      if_id_valid_d       = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      if_id_instruction_q <= NOP;
      if_id_pc_plus4_q    <= '0;
      if_id_valid_q       <= 1'b0;
    end else begin
      if_id_instruction_q <= if_id_instruction_d;
      if_id_pc_plus4_q    <= if_id_pc_plus4_d;
      if_id_valid_q       <= if_id_valid_d;
    end
  end

  assign fif.imem_address      = pc;
  assign fif.if_id_instruction = if_id_instruction_q;
  assign fif.if_id_pc_plus4    = if_id_pc_plus4_q;
  assign fif.if_id_valid       = if_id_valid_q;
  assign fif.opcode            = if_id_instruction_q[31:26];
  assign fif.flush_id_ex       = fif.branch_taken;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus randomized checks of fetch_stage against a cycle-level reference model.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clock = 1'b0;
  logic reset;
  fetch_stage_if fif ();

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clock (clock),
    .reset (reset),
    .fif   (fif)
  );

  always #5 clock = ~clock;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [31:0] m_pc, m_instr, m_pp4;
  logic        m_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".pc"},    fif.imem_address, m_pc);
    chk({tag, ".instr"}, fif.if_id_instruction, m_instr);
    chk({tag, ".pp4"},   fif.if_id_pc_plus4, m_pp4);
    chk({tag, ".valid"}, {31'b0, fif.if_id_valid}, {31'b0, m_valid});
    chk({tag, ".op"},    {26'b0, fif.opcode}, {26'b0, m_instr[31:26]});
  endtask

  // One clock: drive inputs, check combinational outputs, advance the model, check registers.
  task automatic cycle(input string tag, input logic rst, input logic st, input logic br,
                       input logic [31:0] tgt, input logic jp, input logic [31:0] data);
    reset = rst;
    fif.stall = st;
    fif.branch_taken = br;
    fif.branch_target = tgt;
    fif.jump = jp;
    fif.imem_data = data;
    #1;
    chk({tag, ".addr"},  fif.imem_address, m_pc);
    chk({tag, ".flush"}, {31'b0, fif.flush_id_ex}, {31'b0, br});
    if (rst) begin
      m_pc = RST_PC; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
    end else if (br) begin
      m_pc = tgt; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
    end else if (jp && m_valid) begin
      m_pc = {m_pp4[31:28], m_instr[25:0], 2'b00};
      m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
    end else if (!st) begin
      m_instr = data; m_pp4 = m_pc + 32'd4; m_pc = m_pc + 32'd4; m_valid = 1'b1;
    end
    @(posedge clock);
    #1;
    check_regs(tag);
  endtask

  task automatic normal(input string tag, input logic [31:0] data);
    cycle(tag, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, data);
  endtask

  initial begin
    reset = 1'b1;
    fif.stall = 1'b0; fif.branch_taken = 1'b0; fif.branch_target = '0;
    fif.jump = 1'b0;  fif.imem_data = '0;
    m_pc = RST_PC; m_instr = '0; m_pp4 = '0; m_valid = 1'b0;
    @(posedge clock); #1;
    check_regs("reset");
    chk("reset.pc_lit", fif.imem_address, 32'h0);

    // Sequential fetch after reset
    for (int i = 0; i < 4; i++) begin
      chk("seq.addr_lit", fif.imem_address, 32'h4 * i);
      normal("seq", 32'h2008_0005);
      chk("seq.pp4_lit", fif.if_id_pc_plus4, 32'h4 * (i + 1));
      chk("seq.valid_lit", {31'b0, fif.if_id_valid}, 32'h1);
    end

    // Stall two cycles at PC=8
    cycle("rst2", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    normal("pre_stall", 32'h1111_0000);
    normal("pre_stall", 32'h2222_0004);
    chk("stall.at8", fif.imem_address, 32'h8);
    for (int i = 0; i < 2; i++) begin
      cycle("stall", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF);
      chk("stall.hold_pc", fif.imem_address, 32'h8);
      chk("stall.hold_ir", fif.if_id_instruction, 32'h2222_0004);
    end
    normal("resume", 32'h3333_0008);
    chk("resume.pc", fif.imem_address, 32'hC);

    // Branch wins over a simultaneous stall and jump
    cycle("br_stall", 1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h4444_0000);
    chk("br.pc_lit", fif.imem_address, 32'h40);
    chk("br.op_lit", {26'b0, fif.opcode}, 32'h0);

    // Jump on a bubble is ignored
    cycle("jump_bubble", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h5555_0000);
    chk("jump_bubble.pc", fif.imem_address, 32'h44);

    // Jump from IF/ID, with stall in the same cycle
    cycle("to_1000", 1'b0, 1'b0, 1'b1, 32'h1000_0000, 1'b0, 32'h0);
    normal("load_j", 32'h0800_0010);
    cycle("jump", 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h6666_0000);
    chk("jump.pc_lit", fif.imem_address, 32'h1000_0040);
    chk("jump.valid_lit", {31'b0, fif.if_id_valid}, 32'h0);
    chk("jump.ir_lit", fif.if_id_instruction, 32'h0);

    // Wrap at top of address space, then reset during a stall
    cycle("to_top", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    normal("wrap", 32'h7777_0000);
    chk("wrap.pc_lit", fif.imem_address, 32'h0);
    chk("wrap.pp4_lit", fif.if_id_pc_plus4, 32'h0);
    cycle("stall_pre_rst", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle("rst_in_stall", 1'b1, 1'b1, 1'b1, 32'h80, 1'b1, 32'h8888_0000);
    chk("rst_in_stall.pc_lit", fif.imem_address, RST_PC);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic r, s, b, j;
      logic [31:0] t, d;
      r = ($urandom_range(0, 39) == 0);
      b = ($urandom_range(0, 7) == 0);
      j = ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 3) == 0);
      t = $urandom();
      d = $urandom();
      if ($urandom_range(0, 3) == 0) d[31:26] = OP_JUMP;
      cycle("rand", r, s, b, t, j, d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 stall  input  1  load-use hold request from hazard logic.
REQ-005 branch_taken  input  1  branch resolved taken (branch_eq/branch_ne qualified by ALU zero).
REQ-006 branch_target  input  32  byte address of the taken branch.
REQ-007 jump  input  1  jump decoded for the instruction currently in IF/ID.
REQ-008 imem_address  output  32  instruction-memory byte address, equal to the PC.
REQ-009 imem_data  input  32  instruction word; combinational read, valid in the same cycle.
REQ-010 if_id_instruction  output  32  registered instruction for decode.
REQ-011 if_id_pc_plus4  output  32  registered PC+4 of that instruction.
REQ-012 if_id_valid  output  1  IF/ID holds a real instruction; 0 means bubble.
REQ-013 opcode  output  6  if_id_instruction[31:26], driven to the decode control unit.
REQ-014 flush_id_ex  output  1  combinational copy of branch_taken; tells downstream to bubble ID/EX.

Function
REQ-015 PC, IF/ID and valid SHALL update only on a rising clock edge; imem_address SHALL equal the PC combinationally.
REQ-016 Next-state priority SHALL be: reset > branch_taken > jump > stall > normal.
REQ-017 Normal: PC <= PC+4; IF/ID <= {imem_data, PC+4}; valid <= 1.
REQ-018 branch_taken: PC <= branch_target; IF/ID instruction <= NOP (32'h0); valid <= 0; pc_plus4 <= 0.
REQ-019 jump (no branch): PC <= {if_id_pc_plus4[31:28], if_id_instruction[25:0], 2'b00}; IF/ID <= NOP bubble; valid <= 0.
REQ-020 stall (no branch, no jump): PC and all IF/ID outputs SHALL hold their values.
REQ-021 branch_taken with stall or jump in the same cycle: the branch path SHALL win and the stall SHALL be ignored.
REQ-022 jump with stall in the same cycle: the jump path SHALL win.
REQ-023 jump while if_id_valid=0 SHALL be ignored (treated as normal or stall).
REQ-024 PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
REQ-025 branch_target and jump targets SHALL be used unmodified; bits [1:0] are not checked.
REQ-026 Fetch-to-decode latency SHALL be one cycle: the word at PC appears on if_id_instruction after the next edge.

Reset
REQ-027 While reset is sampled high: PC <= RESET_PC, if_id_instruction <= 0, if_id_pc_plus4 <= 0, if_id_valid <= 0, regardless of any other input.
REQ-028 Reset asserted mid-stall or mid-redirect SHALL discard the pending redirect or stall.
REQ-029 First cycle after reset release: imem_address = RESET_PC; valid rises after the following edge.

Structure
REQ-030 The shared pipeline package SHALL hold the NOP encoding (32'h0), the opcode constants (LW, SW, BEQ, BNE, ADDI, ADD, JUMP) and the default RESET_PC.
REQ-031 The PC SHALL be a sub-module pc_register (enable, load value, synchronous reset); the IF/ID register stays inline.
REQ-032 The block SHALL have no combinational path from any input to if_id_* outputs; the only such paths are to flush_id_ex and from the PC to imem_address.

Verification
REQ-033 Reset, then 4 cycles with imem_data = 32'h2008_0005 -> imem_address 0,4,8,C; if_id_pc_plus4 4,8,C; valid=1 from the 2nd edge.
REQ-034 stall=1 for 2 cycles at PC=8 -> imem_address stays 8, IF/ID is frozen, then fetch resumes at 8 -> C.
REQ-035 branch_taken=1, target 32'h40, with stall=1 in the same cycle -> PC=40, valid=0, opcode=0, flush_id_ex=1 that cycle.
REQ-036 IF/ID holds 32'h0800_0010 at pc_plus4 32'h1000_0004, and jump=1 -> PC=32'h1000_0040 and a bubble in IF/ID.
REQ-037 PC=32'hFFFF_FFFC, normal -> PC wraps to 0 and if_id_pc_plus4 = 0; reset asserted during a stall -> PC = RESET_PC, valid=0.
